// File: rtl/ocm_arbiter.sv
// ocm_arbiter: round-robin arbiter for N core ports in front of one single-port word-wide BRAM (load, store, atomic RMW).
// Latency from accept edge: grant cycle 1, read valid cycle 3, plain-write valid cycle 2, AMO write valid 2 cycles after 1111.
// Backpressure: losing cores simply stay pending on i_req; grant is held across both AMO phases; the winner aborts by dropping i_req.
module ocm_arbiter #(
    parameter int N_CORES   = 2,
    parameter int ADDR_BITS = 12
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic [N_CORES-1:0]             i_req,
    input  logic [N_CORES-1:0]             i_atomic,
    input  logic [N_CORES*ADDR_BITS-1:0]   i_addr,
    input  logic [N_CORES*4-1:0]           i_dm_write,
    input  logic [N_CORES*32-1:0]          i_wdata,
    output logic [N_CORES-1:0]             o_grant,
    output logic [N_CORES-1:0]             o_data_valid,
    output logic [N_CORES-1:0]             o_data_write_valid,
    output logic [31:0]                    o_rdata,
    output logic [ADDR_BITS-1:0]           o_mem_addr,
    output logic [3:0]                     o_mem_we,
    output logic [31:0]                    o_mem_wdata,
    input  logic [31:0]                    i_mem_rdata
);

    localparam int IDXW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_RCAP,
        S_RRESP,
        S_AMO_WAIT,
        S_WRITE,
        S_WRESP,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [IDXW-1:0]      win_q, win_d;
    logic [IDXW-1:0]      ptr_q, ptr_d;
    logic                 atomic_q, atomic_d;
    logic [N_CORES-1:0]   served_q, served_d;
    logic [N_CORES-1:0]   grant_q, grant_d;
    logic [N_CORES-1:0]   dv_q, dv_d;
    logic [N_CORES-1:0]   dwv_q, dwv_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;

    logic [ADDR_BITS-1:0] addr_arr [N_CORES];
    logic [3:0]           be_arr   [N_CORES];
    logic [31:0]          wd_arr   [N_CORES];
    logic [N_CORES-1:0]   elig;
    logic                 pick_vld;
    logic [IDXW-1:0]      pick_idx;
    logic                 win_req;
    logic                 wr_active;

    // Split the flat per-core buses into indexable arrays.
    always_comb begin
        for (int k = 0; k < N_CORES; k++) begin
            addr_arr[k] = i_addr[k*ADDR_BITS +: ADDR_BITS];
            be_arr[k]   = i_dm_write[k*4 +: 4];
            wd_arr[k]   = i_wdata[k*32 +: 32];
        end
    end

    // A core that already completed stays ineligible until it drops its request.
    assign elig    = i_req & ~served_q;
    assign win_req = i_req[win_q];

    // Round-robin search: first eligible core starting just after the last winner.
    always_comb begin
        int cand;
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = 0;
        for (int i = 1; i <= N_CORES; i++) begin
            cand = (int'(ptr_q) + i) % N_CORES;
            if (!pick_vld && elig[cand[IDXW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[IDXW-1:0];
            end
        end
    end

    // Transaction sequencer: accept, BRAM read pipeline, AMO hold, write, completion.
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        ptr_d    = ptr_q;
        atomic_d = atomic_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        rdata_d  = rdata_q;
        dv_d     = '0;
        dwv_d    = '0;
        served_d = served_q & i_req;

        if (state_q != S_IDLE && !win_req) begin
            // Winner withdrew: drop everything without writing or marking it served.
            state_d = S_IDLE;
            grant_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_vld) begin
                        win_d             = pick_idx;
                        ptr_d             = pick_idx;
                        atomic_d          = i_atomic[pick_idx];
                        addr_d            = addr_arr[pick_idx];
                        grant_d           = '0;
                        grant_d[pick_idx] = 1'b1;
                        if (i_atomic[pick_idx] || be_arr[pick_idx] == 4'b0000) begin
                            state_d = S_READ;
                        end else begin
                            state_d = S_WRITE;
                        end
                    end
                end
                S_READ: begin
                    state_d = S_RCAP;
                end
                S_RCAP: begin
                    rdata_d = i_mem_rdata;
                    dv_d    = grant_q;
                    state_d = S_RRESP;
                end
                S_RRESP: begin
                    state_d = atomic_q ? S_AMO_WAIT : S_DONE;
                end
                S_AMO_WAIT: begin
                    if (be_arr[win_q] == 4'b1111) begin
                        state_d = S_WRITE;
                    end
                end
                S_WRITE: begin
                    dwv_d   = grant_q;
                    state_d = S_WRESP;
                end
                S_WRESP: begin
                    state_d = S_DONE;
                end
                S_DONE: begin
                    grant_d         = '0;
                    served_d[win_q] = 1'b1;
                    state_d         = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= S_IDLE;
            win_q    <= '0;
            ptr_q    <= IDXW'(N_CORES - 1);
            atomic_q <= 1'b0;
            served_q <= '0;
            grant_q  <= '0;
            dv_q     <= '0;
            dwv_q    <= '0;
            rdata_q  <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            ptr_q    <= ptr_d;
            atomic_q <= atomic_d;
            served_q <= served_d;
            grant_q  <= grant_d;
            dv_q     <= dv_d;
            dwv_q    <= dwv_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
        end
    end

    // Write strobes come straight from the winner, only in WRITE and only while it still requests.
    assign wr_active          = (state_q == S_WRITE) && win_req;
    assign o_mem_we           = wr_active ? be_arr[win_q] : 4'b0000;
    assign o_mem_wdata        = wr_active ? wd_arr[win_q] : 32'h0;
    assign o_mem_addr         = addr_q;
    assign o_grant            = grant_q;
    assign o_data_valid       = dv_q;
    assign o_data_write_valid = dwv_q;
    assign o_rdata            = rdata_q;

endmodule
